vld_sequencer: RTL and testbench
================================

Name: vld_sequencer

Overview:
- Vector-load sequencing stage between the address calculator and the vector register file.
- Takes a computed 16-bit base address and issues NUM_ELEM single-word memory reads on the shared RD/Addr bus.
- Packs the returned 16-bit words into one 256-bit vector and pulses done, so the control FSM can commit the vector in its writeback state.

Parameters:
- NUM_ELEM, 16, number of 16-bit elements per vector; vec_data width = NUM_ELEM*DATA_W.
- DATA_W, 16, memory word and element width.
- RD_LATENCY, 1, cycles from the mem_rd cycle to valid mem_data_in; must be >= 1.

Ports:
- Clk1  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  level request from the control FSM; held high while in the vector-load state.
- base_addr  in  16  effective address of element 0; sampled when start is accepted.
- mem_data_in  in  16  read data from memory.
- mem_addr  out  16  address driven to the memory address mux.
- mem_rd  out  1  read strobe, high for exactly one cycle per element.
- vec_data  out  256  assembled vector; element i occupies bits [16*i+15 : 16*i].
- busy  out  1  high from start acceptance until done.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset (sync, active-high, Clk1): state=IDLE; mem_addr=0; mem_rd=0; vec_data=0; busy=0; done=0; element index=0; armed=1.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If start=1 and armed=1: latch base_addr into the address register, clear vec_data to 0, set index=0, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_rd=1; mem_addr = current element address.
  - Load the latency counter with RD_LATENCY-1; go to WAIT.
- WAIT:
  - mem_rd=0; mem_addr holds its value.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, at that edge write mem_data_in into lane [index].
    - If index = NUM_ELEM-1, go to DONE.
    - Otherwise: index+1, address+1, go to REQ.
- DONE:
  - done=1 for exactly one cycle; busy=0 from the next cycle; set armed=0; go to IDLE.
- Re-arm: armed returns to 1 only on a cycle in IDLE with start=0. A start held high across done does not restart the sequence.
- busy is high in REQ, WAIT and DONE.
- mem_rd and done are decoded from the registered state only, so they are glitch-free.
- Latency: (1+RD_LATENCY) cycles per element. With defaults, done is high in the 33rd cycle after the accepting edge.
- Address arithmetic is 16-bit modulo 2^16: 0xFFFF+1 wraps to 0x0000 with no flag.
- vec_data:
  - Lanes not yet written read 0 during an operation.
  - The full vector holds stable after done until the next start is accepted.
- start deasserted mid-operation: ignored; the sequence completes.
- Reset mid-operation: immediate return to reset values. The partial vector is discarded, and done is not pulsed.
- base_addr changes after acceptance: ignored.

Optional Feature:
- Macro: VLD_STRIDE_EN.
- Defined:
  - Adds input port stride (16 bits), sampled with base_addr at acceptance.
  - Element address = base + i*stride, mod 2^16, computed by accumulating stride each step.
  - stride=0 reads one word NUM_ELEM times.
- Undefined:
  - No stride port; stride is fixed at 1.
  - Identical behaviour otherwise.

Decomposition:
- Shared package vld_pkg:
  - state enum (IDLE/REQ/WAIT/DONE)
  - DATA_W, NUM_ELEM and VEC_W constants
  - element-index width function
- One natural sub-module, vld_addr_gen:
  - address register with load/step and the stride adder.
  - The FSM, latency counter and lane packing stay in vld_sequencer.

Test Plan:
- Basic load: base_addr=0x0100, memory word at A = A^0xA5A5 → mem_rd pulses 16 times at 0x0100..0x010F, each followed by one WAIT cycle. Lane i = (0x0100+i)^0xA5A5. done is high exactly one cycle, 33 cycles after acceptance.
- Wrap-around: base_addr=0xFFFA → addresses 0xFFFA..0xFFFF, then 0x0000..0x0009; all 16 lanes correct.
- Latency: RD_LATENCY=3, memory returning data 3 cycles after mem_rd → 4 cycles per element. done is high in cycle 65; no lane is captured early.
- Start held high: start held high for 100 cycles → exactly one done. Dropping start for 1 cycle and raising it again launches a second load, with vec_data cleared at acceptance.
- Reset mid-load: assert Reset after element 5 is captured → next cycle mem_rd=0, busy=0, vec_data=0, no done. A fresh start runs a full 16-element load.
- Stride (VLD_STRIDE_EN defined): base=0x0200, stride=0x0010 → addresses 0x0200, 0x0210, …, 0x02F0. With stride=0, all 16 reads go to 0x0200.

Source files
------------

// File: rtl/vld_pkg.sv
// Shared types and constants for the vector-load sequencer.
package vld_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_ELEM = 16;
  localparam int VEC_W    = NUM_ELEM * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vld_addr_gen.sv
// Element address register: loads base/stride at acceptance, then steps by
// the latched stride with 16-bit wrap-around.
module vld_addr_gen
  import vld_pkg::*;
#(
  parameter int ADDR_W = DATA_W
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] stride_q;

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      addr     <= '0;
      stride_q <= '0;
    end else if (load) begin
      addr     <= base;
      stride_q <= stride;
    end else if (step) begin
      addr     <= addr + stride_q;
    end
  end

endmodule

// File: rtl/vld_sequencer.sv
// Vector-load sequencer: issues NUM_ELEM single-word reads and packs them
// into one vector. Define VLD_STRIDE_EN to add a stride input port.
module vld_sequencer #(
  parameter int NUM_ELEM   = vld_pkg::NUM_ELEM,
  parameter int DATA_W     = vld_pkg::DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic                         Clk1,
  input  logic                         Reset,
  input  logic                         start,
  input  logic [15:0]                  base_addr,
`ifdef VLD_STRIDE_EN
  input  logic [15:0]                  stride,
`endif
  input  logic [DATA_W-1:0]            mem_data_in,
  output logic [15:0]                  mem_addr,
  output logic                         mem_rd,
  output logic [NUM_ELEM*DATA_W-1:0]   vec_data,
  output logic                         busy,
  output logic                         done
);

  import vld_pkg::*;

  localparam int IDX_W = idx_width(NUM_ELEM);
  localparam int LAT_W = idx_width(RD_LATENCY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

  state_t           state, state_d;
  logic [IDX_W-1:0] index;
  logic [LAT_W-1:0] lat_cnt;
  logic             armed;
  logic             load, step, capture;
  logic [15:0]      stride_val;

`ifdef VLD_STRIDE_EN
  assign stride_val = stride;
`else
  assign stride_val = 16'd1;
`endif

  vld_addr_gen #(.ADDR_W(16)) u_addr_gen (
    .Clk1   (Clk1),
    .Reset  (Reset),
    .load   (load),
    .step   (step),
    .base   (base_addr),
    .stride (stride_val),
    .addr   (mem_addr)
  );

  always_ff @(posedge Clk1) begin
    if (Reset) state <= IDLE;
    else       state <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: if (start && armed) begin
        load    = 1'b1;
        state_d = REQ;
      end
      REQ:  state_d = WAIT;
      WAIT: if (lat_cnt == '0) begin
        capture = 1'b1;
        if (index == LAST_IDX) begin
          state_d = DONE;
        end else begin
          step    = 1'b1;
          state_d = REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state register.
  assign mem_rd = (state == REQ);
  assign done   = (state == DONE);
  assign busy   = (state != IDLE);

  // NOTE: vec_data is a flat register, not a RAM, so it is reset along with
  // the control state; an aborted load must read back as all zeros.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      index    <= '0;
      lat_cnt  <= '0;
      armed    <= 1'b1;
      vec_data <= '0;
    end else begin
      if (load) begin
        index    <= '0;
        vec_data <= '0;
      end
      // Only a visible drop of start re-arms, so a held request runs once.
      if (state == IDLE && !start) armed <= 1'b1;
      if (state == DONE)           armed <= 1'b0;
      if (state == REQ)
        lat_cnt <= LAT_LOAD;
      else if (state == WAIT && lat_cnt != '0)
        lat_cnt <= lat_cnt - 1'b1;
      if (capture) vec_data[index*DATA_W +: DATA_W] <= mem_data_in;
      if (step)    index <= index + 1'b1;
    end
  end

endmodule

// File: tb/tb_vld_sequencer.sv
// Self-checking bench for vld_sequencer: random loads against a behavioural
// model (address = base + i*stride, lane = f(address)), plus a latency-3 DUT.
module tb_vld_sequencer;

  logic         Clk1 = 1'b0;
  logic         Reset = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  base_addr = '0;
  logic [15:0]  stride = 16'd1;
  logic [15:0]  mem_data_in;
  logic [15:0]  mem_addr;
  logic         mem_rd;
  logic [255:0] vec_data;
  logic         busy, done;

  logic         start3 = 1'b0;
  logic [15:0]  base3 = '0;
  logic [15:0]  stride3 = 16'd1;
  logic [15:0]  mdi3;
  logic [15:0]  maddr3;
  logic         mrd3;
  logic [255:0] vec3;
  logic         busy3, done3;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] key = 16'hA5A5;

  always #5 Clk1 = ~Clk1;

  vld_sequencer dut (
    .Clk1(Clk1), .Reset(Reset), .start(start), .base_addr(base_addr),
`ifdef VLD_STRIDE_EN
    .stride(stride),
`endif
    .mem_data_in(mem_data_in), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .vec_data(vec_data), .busy(busy), .done(done)
  );

  vld_sequencer #(.RD_LATENCY(3)) dut3 (
    .Clk1(Clk1), .Reset(Reset), .start(start3), .base_addr(base3),
`ifdef VLD_STRIDE_EN
    .stride(stride3),
`endif
    .mem_data_in(mdi3), .mem_addr(maddr3), .mem_rd(mrd3),
    .vec_data(vec3), .busy(busy3), .done(done3)
  );

  // Memory models: word at A is A^key, returned L cycles after the mem_rd
  // cycle; any other cycle returns junk so early captures are visible.
  logic [15:0] pipe1;
  logic [15:0] pipe3 [3];
  always @(posedge Clk1) begin
    pipe1    <= mem_rd ? (mem_addr ^ key) : 16'hDEAD;
    pipe3[0] <= mrd3 ? (maddr3 ^ key) : 16'hBEEF;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_data_in = pipe1;
  assign mdi3        = pipe3[2];

  function automatic logic [15:0] elem_addr(input logic [15:0] b,
                                            input logic [15:0] s, input int i);
    logic [15:0] ii;
    ii = 16'(i);
    return b + ii * s;
  endfunction

  function automatic logic [15:0] eff_stride(input logic [15:0] s);
`ifdef VLD_STRIDE_EN
    return s;
`else
    return 16'd1;
`endif
  endfunction

  task automatic cmp(input string name, input logic [255:0] got,
                     input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One full load on the latency-1 DUT; checks reads, timing and vector.
  task automatic run_load(input string name, input logic [15:0] base,
                          input logic [15:0] s, input bit keep_start,
                          output logic [255:0] exp_vec);
    logic [15:0] addrs[$];
    logic [15:0] es;
    int done_at, n_done;
    es = eff_stride(s);
    for (int i = 0; i < 16; i++)
      exp_vec[i*16 +: 16] = elem_addr(base, es, i) ^ key;
    @(negedge Clk1);
    start = 1'b1; base_addr = base; stride = s;
    @(posedge Clk1);
    done_at = 0; n_done = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk1);
      if (k == 1) begin
        cmp({name, " cleared"}, vec_data, '0);
        cmp({name, " busy"}, {255'd0, busy}, 256'd1);
        base_addr = 16'($urandom);
        stride    = 16'($urandom);
        if (!keep_start) start = 1'b0;
      end
      if (mem_rd) addrs.push_back(mem_addr);
      if (done) begin
        n_done++;
        if (done_at == 0) done_at = k;
      end
    end
    cmp({name, " done count"}, 256'(n_done), 256'd1);
    cmp({name, " done cycle"}, 256'(done_at), 256'd33);
    cmp({name, " reads"}, 256'(addrs.size()), 256'd16);
    if (addrs.size() == 16)
      for (int i = 0; i < 16; i++)
        cmp($sformatf("%s addr[%0d]", name, i), 256'(addrs[i]),
            256'(elem_addr(base, es, i)));
    cmp({name, " vector"}, vec_data, exp_vec);
    cmp({name, " idle"}, {254'd0, busy, done}, 256'd0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk1);
    cmp("reset outs", {mem_addr, mem_rd, busy, done}, '0);
    cmp("reset vec", vec_data, '0);
    cmp("reset outs3", {maddr3, mrd3, busy3, done3, vec3}, '0);
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [255:0] v;
    key = 16'hA5A5;
    run_load("basic", 16'h0100, 16'd1, 1'b0, v);
  endtask

  task automatic test_wrap();
    logic [255:0] v;
    run_load("wrap", 16'hFFFA, 16'd1, 1'b0, v);
  endtask

  task automatic test_random();
    logic [255:0] v;
    for (int n = 0; n < 4; n++) begin
      key = 16'($urandom);
      run_load($sformatf("rand%0d", n), 16'($urandom), 16'($urandom), 1'b0, v);
    end
  endtask

  task automatic test_start_held();
    logic [255:0] v;
    int extra;
    key = 16'h3C5A;
    run_load("held1", 16'h4000, 16'd1, 1'b1, v);
    extra = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge Clk1);
      if (done || mem_rd) extra++;
    end
    cmp("held no restart", 256'(extra), 256'd0);
    cmp("held vec stable", vec_data, v);
    @(negedge Clk1);
    start = 1'b0;
    run_load("held2", 16'h5000, 16'd1, 1'b0, v);
  endtask

  task automatic test_reset_mid();
    logic [15:0] b;
    logic [255:0] v;
    int n_done;
    b = 16'($urandom);
    key = 16'h0F0F;
    @(negedge Clk1);
    start = 1'b1; base_addr = b;
    @(posedge Clk1);
    for (int k = 1; k <= 13; k++) begin
      @(negedge Clk1);
      if (k == 1) start = 1'b0;
    end
    cmp("mid lane5", 256'(vec_data[5*16 +: 16]), 256'(elem_addr(b, 16'd1, 5) ^ key));
    cmp("mid lane6", 256'(vec_data[6*16 +: 16]), 256'd0);
    Reset = 1'b1;
    @(negedge Clk1);
    cmp("rst mid outs", {mem_rd, busy, done}, '0);
    cmp("rst mid vec", vec_data, '0);
    Reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk1);
      if (done || busy) n_done++;
    end
    cmp("rst mid no done", 256'(n_done), 256'd0);
    run_load("after rst", 16'($urandom), 16'd1, 1'b0, v);
  endtask

  task automatic test_latency();
    logic [255:0] exp_vec;
    logic [15:0] addrs[$];
    logic [15:0] b;
    int done_at, n_done;
    b = 16'($urandom);
    key = 16'h9A61;
    for (int i = 0; i < 16; i++) exp_vec[i*16 +: 16] = elem_addr(b, 16'd1, i) ^ key;
    @(negedge Clk1);
    start3 = 1'b1; base3 = b; stride3 = 16'd1;
    @(posedge Clk1);
    done_at = 0; n_done = 0;
    for (int k = 1; k <= 75; k++) begin
      @(negedge Clk1);
      if (k == 1) begin start3 = 1'b0; base3 = 16'($urandom); end
      if (mrd3) addrs.push_back(maddr3);
      if (done3) begin
        n_done++;
        if (done_at == 0) done_at = k;
      end
    end
    cmp("lat3 done count", 256'(n_done), 256'd1);
    cmp("lat3 done cycle", 256'(done_at), 256'd65);
    cmp("lat3 reads", 256'(addrs.size()), 256'd16);
    cmp("lat3 vector", vec3, exp_vec);
  endtask

`ifdef VLD_STRIDE_EN
  task automatic test_stride();
    logic [255:0] v;
    key = 16'h1234;
    run_load("stride16", 16'h0200, 16'h0010, 1'b0, v);
    run_load("stride0", 16'h0200, 16'h0000, 1'b0, v);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_start_held();
    test_reset_mid();
    test_latency();
`ifdef VLD_STRIDE_EN
    test_stride();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
